// File: rtl/pipe_pkg.sv
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared constants for the elastic pipeline-stage register:
//                occupancy state encoding and default MEM/WB payload offsets.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

   // Occupancy state encoding (main/skid register fill level)
   localparam logic [1:0] EMPTY = 2'd0;
   localparam logic [1:0] FULL  = 2'd1;
   localparam logic [1:0] SKID  = 2'd2;

   // Default MEM/WB payload packing: {rd[3:0], Mem_Out[15:0], Result[15:0]}
   localparam int RD_LSB     = 32;
   localparam int MEMOUT_LSB = 16;
   localparam int RESULT_LSB = 0;

endpackage : pipe_pkg

`default_nettype wire

// File: rtl/pipe_stage_reg.sv
// ============================================================================
//  Module      : pipe_stage_reg
//  Description : Elastic pipeline-stage register with valid/ready handshake,
//                one-entry skid buffer, synchronous flush and a saturating
//                stall counter.
//  Ports       : clk        - clock, rising edge
//                reset      - asynchronous active-low reset
//                in_valid   - upstream beat present
//                in_ready   - stage can accept a beat (registered)
//                in_ctrl    - upstream control word
//                in_data    - upstream payload
//                flush      - synchronous kill of held and incoming beats
//                out_valid  - downstream beat present
//                out_ready  - downstream accepts the beat
//                out_ctrl   - control word, zero when out_valid=0
//                out_data   - payload, holds last value when out_valid=0
//                stat_clr   - clears the stall counter
//                stall_cnt  - saturating count of stalled output cycles
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int CTRL_W = 2,
   parameter int DATA_W = 36,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   input  logic              stat_clr,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam logic [CNT_W-1:0] c_cnt_max = '1;
   localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

   logic [CTRL_W-1:0] r_main_ctrl;
   logic [DATA_W-1:0] r_main_data;
   logic              r_main_v;
   logic [CTRL_W-1:0] r_skid_ctrl;
   logic [DATA_W-1:0] r_skid_data;
   logic              r_skid_v;
   logic [CNT_W-1:0]  r_stall_cnt;

   logic              w_acc;
   logic              w_dq;
   logic [1:0]        w_state;

   // in_ready is the inverted skid flag, so it comes straight from a flop
   assign w_acc   = in_valid & ~r_skid_v;
   assign w_dq    = r_main_v & out_ready;
   // The valid flags are the state: skid is only ever occupied with main
   assign w_state = {r_skid_v, r_main_v & ~r_skid_v};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_main_ctrl <= '0;
         r_main_data <= '0;
         r_main_v    <= 1'b0;
         r_skid_ctrl <= '0;
         r_skid_data <= '0;
         r_skid_v    <= 1'b0;
      end else if (flush) begin
         // Kill both beats; data registers keep their contents
         r_main_v <= 1'b0;
         r_skid_v <= 1'b0;
      end else begin
         case (w_state)
            EMPTY: begin
               if (w_acc) begin
                  r_main_ctrl <= in_ctrl;
                  r_main_data <= in_data;
                  r_main_v    <= 1'b1;
               end
            end
            FULL: begin
               if (w_acc && w_dq) begin
                  r_main_ctrl <= in_ctrl;
                  r_main_data <= in_data;
               end else if (w_acc) begin
                  // Downstream stalled: park the extra beat in skid
                  r_skid_ctrl <= in_ctrl;
                  r_skid_data <= in_data;
                  r_skid_v    <= 1'b1;
               end else if (w_dq) begin
                  r_main_v <= 1'b0;
               end
            end
            SKID: begin
               if (w_dq) begin
                  r_main_ctrl <= r_skid_ctrl;
                  r_main_data <= r_skid_data;
                  r_skid_v    <= 1'b0;
               end
            end
            default: begin
               r_main_v <= 1'b0;
               r_skid_v <= 1'b0;
            end
         endcase
      end
   end

   // Stall counter: clear wins over increment, saturates at all-ones
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_stall_cnt <= '0;
      end else if (stat_clr) begin
         r_stall_cnt <= '0;
      end else if (r_main_v && !out_ready && (r_stall_cnt != c_cnt_max)) begin
         r_stall_cnt <= r_stall_cnt + c_cnt_one;
      end
   end

   assign in_ready  = ~r_skid_v;
   assign out_valid = r_main_v;
   assign out_ctrl  = r_main_ctrl & {CTRL_W{r_main_v}};
   assign out_data  = r_main_data;
   assign stall_cnt = r_stall_cnt;

endmodule : pipe_stage_reg

`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
// ============================================================================
//  Module      : tb_pipe_stage_reg
//  Description : Self-checking bench for pipe_stage_reg (CTRL_W=2, DATA_W=36,
//                CNT_W=4) with a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_stage_reg;

   typedef struct {
      logic [1:0]  ctrl;
      logic [35:0] data;
   } beat_t;

   logic        clk       = 1'b0;
   logic        reset     = 1'b0;
   logic        in_valid  = 1'b0;
   logic [1:0]  in_ctrl   = '0;
   logic [35:0] in_data   = '0;
   logic        flush     = 1'b0;
   logic        out_ready = 1'b0;
   logic        stat_clr  = 1'b0;
   wire         in_ready;
   wire         out_valid;
   wire  [1:0]  out_ctrl;
   wire  [35:0] out_data;
   wire  [3:0]  stall_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   pipe_stage_reg #(.CTRL_W(2), .DATA_W(36), .CNT_W(4)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_ctrl   (in_ctrl),
      .in_data   (in_data),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_ctrl  (out_ctrl),
      .out_data  (out_data),
      .stat_clr  (stat_clr),
      .stall_cnt (stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the stage is a FIFO of depth two whose input is open
   // whenever fewer than two beats are held.
   beat_t       q[$];
   logic [35:0] m_data = '0;
   logic [3:0]  m_cnt  = '0;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         q.delete();
         m_data <= '0;
         m_cnt  <= '0;
      end else begin
         automatic bit    rdy = (q.size() < 2);
         automatic bit    ov  = (q.size() > 0);
         automatic bit    acc = in_valid && rdy;
         automatic bit    dq  = ov && out_ready;
         automatic beat_t b;
         b.ctrl = in_ctrl;
         b.data = in_data;
         if (stat_clr)
            m_cnt <= '0;
         else if (ov && !out_ready && m_cnt != 4'd15)
            m_cnt <= m_cnt + 4'd1;
         if (flush) begin
            q.delete();
         end else begin
            if (dq) void'(q.pop_front());
            if (acc) q.push_back(b);
         end
         if (q.size() > 0) m_data <= q[0].data;
      end
   end

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      automatic bit         e_v  = (q.size() > 0);
      automatic logic [1:0] e_c  = e_v ? q[0].ctrl : 2'b00;
      chk("out_valid", 64'(out_valid), 64'(e_v));
      chk("out_ctrl",  64'(out_ctrl),  64'(e_c));
      chk("out_data",  64'(out_data),  64'(m_data));
      chk("in_ready",  64'(in_ready),  64'(q.size() < 2));
      chk("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
   end

   task automatic cyc(input logic v, input logic [1:0] c, input logic [35:0] d,
                      input logic ordy, input logic fl, input logic sc);
      in_valid  = v;
      in_ctrl   = c;
      in_data   = d;
      out_ready = ordy;
      flush     = fl;
      stat_clr  = sc;
      @(negedge clk);
   endtask

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_ctrl",  64'(out_ctrl),  64'd0);
      chk("rst_out_data",  64'(out_data),  64'd0);
      chk("rst_in_ready",  64'(in_ready),  64'd1);
      chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
      #2 reset = 1'b1;
      @(negedge clk);

      // Fill both registers, then reset asynchronously mid-stream
      cyc(1'b1, 2'b01, 36'd1, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 2'b01, 36'd2, 1'b0, 1'b0, 1'b0);
      chk("skid_in_ready", 64'(in_ready),  64'd0);
      chk("skid_valid",    64'(out_valid), 64'd1);
      #1 reset = 1'b0;
      #1;
      chk("arst_out_valid", 64'(out_valid), 64'd0);
      chk("arst_out_ctrl",  64'(out_ctrl),  64'd0);
      chk("arst_in_ready",  64'(in_ready),  64'd1);
      #1 reset = 1'b1;
      cyc(1'b1, 2'b00, 36'h0A5A5, 1'b1, 1'b0, 1'b0);
      chk("first_valid", 64'(out_valid),      64'd1);
      chk("first_data",  64'(out_data[15:0]), 64'hA5A5);

      // Streaming with out_ready high
      for (int i = 1; i <= 8; i++) begin
         cyc(1'b1, 2'b00, 36'(i), 1'b1, 1'b0, 1'b0);
         chk("stream_data",  64'(out_data),  64'(i));
         chk("stream_ready", 64'(in_ready),  64'd1);
         chk("stream_cnt",   64'(stall_cnt), 64'd0);
      end
      cyc(1'b0, 2'b00, 36'd0, 1'b1, 1'b0, 1'b0);
      chk("stream_drain", 64'(out_valid), 64'd0);

      // Three-cycle backpressure with in_valid held
      cyc(1'b1, 2'b00, 36'd1, 1'b1, 1'b0, 1'b0);
      chk("bp_first", 64'(out_data), 64'd1);
      cyc(1'b1, 2'b00, 36'd2, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 2'b00, 36'd3, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 2'b00, 36'd3, 1'b0, 1'b0, 1'b0);
      chk("bp_ready_low", 64'(in_ready),  64'd0);
      chk("bp_hold",      64'(out_data),  64'd1);
      chk("bp_cnt",       64'(stall_cnt), 64'd3);
      cyc(1'b1, 2'b00, 36'd3, 1'b1, 1'b0, 1'b0);
      chk("bp_second", 64'(out_data), 64'd2);
      cyc(1'b1, 2'b00, 36'd3, 1'b1, 1'b0, 1'b0);
      chk("bp_third",  64'(out_data), 64'd3);
      cyc(1'b0, 2'b00, 36'd0, 1'b1, 1'b0, 1'b0);
      chk("bp_empty",   64'(out_valid), 64'd0);
      chk("bp_cnt_end", 64'(stall_cnt), 64'd3);

      // Flush while in SKID with a beat offered
      cyc(1'b1, 2'b11, 36'd10, 1'b0, 1'b0, 1'b1);
      chk("fl_ctrl", 64'(out_ctrl), 64'd3);
      cyc(1'b1, 2'b11, 36'd11, 1'b0, 1'b0, 1'b0);
      chk("fl_skid", 64'(in_ready), 64'd0);
      cyc(1'b1, 2'b11, 36'd12, 1'b0, 1'b1, 1'b0);
      chk("fl_valid", 64'(out_valid), 64'd0);
      chk("fl_ctrl0", 64'(out_ctrl),  64'd0);
      chk("fl_ready", 64'(in_ready),  64'd1);
      chk("fl_cnt",   64'(stall_cnt), 64'd2);
      repeat (2) begin
         cyc(1'b0, 2'b00, 36'd0, 1'b1, 1'b0, 1'b0);
         chk("fl_dropped", 64'(out_valid), 64'd0);
         chk("fl_hold",    64'(out_data),  64'd10);
      end

      // Counter saturation and clear-over-stall
      cyc(1'b1, 2'b00, 36'd5, 1'b0, 1'b0, 1'b1);
      repeat (20) cyc(1'b0, 2'b00, 36'd0, 1'b0, 1'b0, 1'b0);
      chk("sat_cnt", 64'(stall_cnt), 64'd15);
      cyc(1'b0, 2'b00, 36'd0, 1'b0, 1'b0, 1'b1);
      chk("clr_cnt", 64'(stall_cnt), 64'd0);
      cyc(1'b0, 2'b00, 36'd0, 1'b1, 1'b0, 1'b0);

      // Randomized traffic, checked every cycle by the model
      for (int i = 0; i < 3000; i++) begin
         logic [35:0] d;
         d[31:0]  = $urandom();
         d[35:32] = 4'($urandom());
         cyc($urandom_range(0, 3) != 0, 2'($urandom()), d,
             $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0,
             $urandom_range(0, 29) == 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_pipe_stage_reg

`default_nettype wire

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised, elastic pipeline-stage register for the 16-bit core, the successor to the fixed-field inter-stage registers. It carries a control word and a data word between stages under a valid/ready handshake, and adds a one-entry skid buffer, a synchronous flush and a saturating stall counter. It is instantiated once per stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB), with widths chosen per boundary.

## Interface
- CTRL_W, default 2: control-field width; bits such as Write_Enable and Write_Back_Sel, forced to zero on bubbles.
- DATA_W, default 36: payload width; default packs rd[3:0], Mem_Out[15:0] and Result[15:0].
- CNT_W, default 16: stall-counter width.

- clk: input, 1. Single clock; all state updates on the rising edge.
- reset: input, 1. Asynchronous, active-low. Low clears all state immediately.
- in_valid: input, 1. Upstream beat present.
- in_ready: output, 1. Stage can accept a beat. Registered.
- in_ctrl: input, CTRL_W. Upstream control word.
- in_data: input, DATA_W. Upstream payload.
- flush: input, 1. Synchronous kill of all held and incoming beats.
- out_valid: output, 1. Downstream beat present.
- out_ready: input, 1. Downstream accepts the beat.
- out_ctrl: output, CTRL_W. Control word, equal to zero whenever out_valid=0.
- out_data: output, DATA_W. Payload; holds its last value when out_valid=0.
- stat_clr: input, 1. Clears the stall counter.
- stall_cnt: output, CNT_W. Cycles with out_valid=1 and out_ready=0.

## Operation
- Storage consists of a main register (main_ctrl, main_data, main_v) and a skid register (skid_ctrl, skid_data, skid_v).
- The outputs are taken from the main register. out_ctrl = main_ctrl AND {CTRL_W{main_v}}.
- in_ready = ~skid_v, taken directly from the flop.
- acc = in_valid & in_ready.
- dq = main_v & out_ready.
- States:
  - EMPTY: main_v=0, skid_v=0.
  - FULL: main_v=1, skid_v=0.
  - SKID: main_v=1, skid_v=1.
- Transitions (flush=0):
  - EMPTY: acc → FULL, main ← in. Otherwise stay.
  - FULL, acc & dq: stay FULL, main ← in.
  - FULL, acc & ~dq: → SKID, skid ← in.
  - FULL, ~acc & dq: → EMPTY.
  - FULL, otherwise: stay, main holds.
  - SKID: acc is impossible because in_ready=0. dq → FULL, main ← skid. Otherwise stay.
- Flush has highest priority. On the next edge the state goes to EMPTY and main_v=skid_v=0. A beat offered in the flush cycle is dropped. Data registers are left unchanged.
- Stall counter:
  - Increments when main_v & ~out_ready.
  - Saturates at 2^CNT_W−1.
  - stat_clr takes priority and loads 0. When stat_clr and a stall coincide, the result is 0.
  - flush does not affect the counter.
- Widths: ctrl and data pass through unmodified. No arithmetic except the counter.

## Timing
- Reset (low), all applied asynchronously: out_valid=0, out_ctrl=0, out_data=0, in_ready=1, stall_cnt=0, state EMPTY, skid_ctrl/skid_data=0.
- Reset release is synchronous to clk. The first accept can occur on the first rising edge after release.
- Latency: a beat accepted at edge N appears on out_* after edge N (one cycle).
- Throughput is one beat per cycle with out_ready held high. The skid register is never used in that case.
- in_ready falls one cycle after the first unaccepted output cycle. Exactly one extra beat is absorbed, so no beat is lost while upstream reacts to in_ready.
- Reset asserted mid-operation discards both held beats, including a beat in SKID.
- Ordering is strictly FIFO. The skid beat is always delivered after the main beat.

## Structure
- Package pipe_pkg holds:
  - the state encoding localparams EMPTY=2'd0, FULL=2'd1, SKID=2'd2;
  - the default MEM/WB field offsets RD_LSB=32, MEMOUT_LSB=16, RESULT_LSB=0.
- No sub-module: the stall counter and the skid register are inline.
- The existing MEM_WB_Reg call site maps to CTRL_W=2, DATA_W=36 with out_ready tied to 1.

## Test plan
- Reset low mid-stream with both registers full: out_valid=0, out_ctrl=0, in_ready=1 immediately. After release, 0xA5A5 is accepted, and out_valid=1 with out_data[15:0]=0xA5A5 one edge later.
- Streaming 8 beats (data 1..8) with out_ready=1: outputs 1..8 on consecutive cycles, in_ready constantly 1, stall_cnt=0.
- out_ready low for 3 cycles while in_valid is held, then high: in_ready drops once the skid register fills. The output order is 1,2,3 with no loss or duplication. stall_cnt=3.
- flush in SKID state with in_valid=1: next edge gives out_valid=0 and in_ready=1, and the offered beat never appears. With CTRL_W=2, ctrl 2'b11 in flight gives out_ctrl=0.
- CNT_W=4, out_ready=0 for 20 cycles: stall_cnt saturates at 15. stat_clr asserted together with a stall gives 0 on the next edge.
